// File: rtl/firmware_config_sequencer.sv
// Purpose: stream host firmware bytes onto the shared configId/configData bus, draining trace first.
// Latency: accept -> DRAIN_CYCLES+1 idle-pipe cycles -> data wait -> len gap-free bytes -> 1 done cycle.
// Backpressure: host_ready drops when the byte FIFO is full; cmd_ready is high only while idle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   host_valid/host_data/host_ready   firmware byte push port (valid/ready)
//   cmd_valid/cmd_unit_id/cmd_len/cmd_ready   reconfiguration request (valid/ready)
//   tracing_req, pipe_busy     desired tracing state, trace-pipeline activity
//   tracing, configId, configData     registered outputs to every configurable block
//   busy, done                 sequencer active, one-cycle end-of-command pulse
module firmware_config_sequencer #(
    parameter int         FIFO_DEPTH   = 32,
    parameter int         DRAIN_CYCLES = 4,
    parameter logic [7:0] IDLE_ID      = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_unit_id,
    input  logic [7:0] cmd_len,
    output logic       cmd_ready,
    input  logic       tracing_req,
    input  logic       pipe_busy,
    output logic       tracing,
    output logic [7:0] configId,
    output logic [7:0] configData,
    output logic       busy,
    output logic       done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_WAIT,
        S_STREAM,
        S_GAP
    } state_t;

    state_t state, next_state;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          fifo_push, fifo_pop;

    assign host_ready = (fifo_count != FULL_CNT);
    assign fifo_push  = host_valid && host_ready;
    assign fifo_head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command context and counters
    // ------------------------------------------------------------------
    logic [7:0]    unit_q;
    logic [7:0]    len_q;
    logic [7:0]    rem_q;      // bytes still to send after the one currently on the bus
    logic [DW-1:0] drain_cnt;
    logic          data_ready;

    // Wait for the whole burst so the target's byte counter never sees a hole.
    assign data_ready = (32'(fifo_count) >= 32'(len_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            unit_q    <= IDLE_ID;
            len_q     <= '0;
            rem_q     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        unit_q    <= cmd_unit_id;
                        len_q     <= cmd_len;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    // Only an unbroken run of idle cycles counts.
                    if (pipe_busy) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt != DRAIN_MAX) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    rem_q <= len_q - 8'd1;
                end
                S_STREAM: begin
                    if (rem_q != 8'd0) begin
                        rem_q <= rem_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_MAX) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_ready) begin
                    next_state = (len_q == 8'd0) ? S_GAP : S_STREAM;
                end
            end
            S_STREAM: begin
                if (rem_q == 8'd0) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Bus outputs are registered from next_state so that the
    // registered value lines up with the cycle the FSM spends in that state.
    // ------------------------------------------------------------------
    logic       tracing_d;
    logic [7:0] config_id_d;
    logic [7:0] config_data_d;
    logic       done_d;

    always_comb begin
        fifo_pop      = (next_state == S_STREAM);
        config_id_d   = fifo_pop ? unit_q : IDLE_ID;
        config_data_d = fifo_pop ? fifo_head : 8'h00;
        done_d        = (next_state == S_GAP);
        busy          = (state != S_IDLE);
        cmd_ready     = (state == S_IDLE);
        case (next_state)
            S_IDLE:  tracing_d = tracing_req;
            S_DRAIN: tracing_d = tracing;   // frozen while the pipe drains
            default: tracing_d = 1'b0;      // low from WAIT through GAP
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tracing    <= 1'b0;
            configId   <= IDLE_ID;
            configData <= 8'h00;
            done       <= 1'b0;
        end else begin
            tracing    <= tracing_d;
            configId   <= config_id_d;
            configData <= config_data_d;
            done       <= done_d;
        end
    end

endmodule
